// File: rtl/board_gen_if.sv
// board_gen_if: cursor/game-side interface of the Minesweeper board generator.
//   master : game/button logic - drives start, seed_in, safe_x/safe_y and the
//            readback coordinates; observes cell_val, num_mines, busy, ready, done.
//   slave  : board_gen itself.
// Signals:
//   start      1-cycle pulse, begin a new board
//   seed_in    32-bit PRNG seed sampled on an accepted start
//   safe_x/y   first-click cell (only used when BOARD_SAFE_START_EN is defined)
//   x_coord/y  readback cell coordinates
//   cell_val   registered readback: 5'h1F = mine, else neighbour count 0..8
//   num_mines  mines placed so far
//   busy/ready generation in progress / board complete
//   done       1-cycle pulse on entry to READY
interface board_gen_if #(
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
);
  logic                     start;
  logic [31:0]              seed_in;
  logic [X_BITS-1:0]        safe_x;
  logic [Y_BITS-1:0]        safe_y;
  logic [X_BITS-1:0]        x_coord;
  logic [Y_BITS-1:0]        y_coord;
  logic [4:0]               cell_val;
  logic [X_BITS+Y_BITS-1:0] num_mines;
  logic                     busy;
  logic                     ready;
  logic                     done;

  modport master (
    output start, seed_in, safe_x, safe_y, x_coord, y_coord,
    input  cell_val, num_mines, busy, ready, done
  );

  modport slave (
    input  start, seed_in, safe_x, safe_y, x_coord, y_coord,
    output cell_val, num_mines, busy, ready, done
  );
endinterface

// File: rtl/board_gen.sv
// board_gen: Minesweeper board generator with an exact mine count.
// On an accepted start the board is cleared (one cell per cycle), exactly
// NUM_MINES mines are placed at xorshift32-chosen cells (out-of-range or
// already-mined candidates are rejected, one cycle each), then every non-mine
// cell receives its 8-neighbour mine count (one cell per cycle) and ready rises.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous, active-high; wins over start
//   bus    board_gen_if.slave (start/seed/safe cell/readback/status)
// Optional feature macro: BOARD_SAFE_START_EN - when defined, safe_x/safe_y
// are sampled on start and the 3x3 block around that cell never gets a mine.
module board_gen #(
  parameter int X_SIZE    = 16,
  parameter int Y_SIZE    = 16,
  parameter int X_BITS    = 4,
  parameter int Y_BITS    = 4,
  parameter int NUM_MINES = 40
) (
  input  logic        clk,
  input  logic        reset,
  board_gen_if.slave  bus
);

  localparam int                        CB        = X_BITS + Y_BITS;
  localparam logic [4:0]                MINE      = 5'h1F;
  localparam logic [31:0]               SEED_DEF  = 32'h1234_5678;
  localparam logic [X_BITS-1:0]         X_LAST    = X_BITS'(X_SIZE - 1);
  localparam logic [Y_BITS-1:0]         Y_LAST    = Y_BITS'(Y_SIZE - 1);
  localparam logic [X_BITS-1:0]         X_ONE     = X_BITS'(1);
  localparam logic [Y_BITS-1:0]         Y_ONE     = Y_BITS'(1);
  localparam logic [CB-1:0]             CNT_ONE   = CB'(1);
  localparam logic [CB-1:0]             MINES_TGT = CB'(NUM_MINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PLACE,
    S_COUNT,
    S_READY
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         prng_q, prng_d;
  logic [X_BITS-1:0]   px_q, px_d;
  logic [Y_BITS-1:0]   py_q, py_d;
  logic [CB-1:0]       nmines_q, nmines_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [4:0]          cell_val_q;

  logic [4:0]          mem_q [Y_SIZE][X_SIZE];

  logic                we;
  logic [X_BITS-1:0]   wx;
  logic [Y_BITS-1:0]   wy;
  logic [4:0]          wd;

  logic [X_BITS-1:0]   cand_x;
  logic [Y_BITS-1:0]   cand_y;
  logic                cand_free;
  logic                in_safe;
  logic [3:0]          nbr_cnt;
  int                  nx, ny;

  function automatic logic [31:0] xorshift32(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  assign cand_x = prng_q[X_BITS-1:0];
  assign cand_y = prng_q[CB-1:X_BITS];

`ifdef BOARD_SAFE_START_EN
  logic [X_BITS-1:0] safe_x_q, safe_x_d;
  logic [Y_BITS-1:0] safe_y_q, safe_y_d;
  logic [X_BITS:0]   cxe, sxe;
  logic [Y_BITS:0]   cye, sye;

  // One extra bit so that safe_x+1 at the top column cannot wrap to 0.
  always_comb begin
    cxe     = {1'b0, cand_x};
    sxe     = {1'b0, safe_x_q};
    cye     = {1'b0, cand_y};
    sye     = {1'b0, safe_y_q};
    in_safe = (cxe + (X_BITS+1)'(1) >= sxe) && (cxe <= sxe + (X_BITS+1)'(1)) &&
              (cye + (Y_BITS+1)'(1) >= sye) && (cye <= sye + (Y_BITS+1)'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      safe_x_q <= '0;
      safe_y_q <= '0;
    end else begin
      safe_x_q <= safe_x_d;
      safe_y_q <= safe_y_d;
    end
  end
`else
  logic unused_safe;
  assign unused_safe = ^{bus.safe_x, bus.safe_y};
  assign in_safe     = 1'b0;
`endif

  // Candidate acceptance for the current PRNG value.
  always_comb begin
    cand_free = 1'b0;
    if (32'(cand_x) < X_SIZE && 32'(cand_y) < Y_SIZE)
      cand_free = (mem_q[cand_y][cand_x] != MINE) && !in_safe;
  end

  // Neighbour mine count of the cell under the raster pointer. Cells already
  // visited in COUNT hold 0..8, never 5'h1F, so mine tests remain exact.
  always_comb begin
    nbr_cnt = '0;
    nx      = 0;
    ny      = 0;
    for (int unsigned j = 0; j < 3; j++) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (!(i == 1 && j == 1)) begin
          nx = int'(px_q) + int'(i) - 1;
          ny = int'(py_q) + int'(j) - 1;
          if (nx >= 0 && nx < X_SIZE && ny >= 0 && ny < Y_SIZE) begin
            if (mem_q[ny[Y_BITS-1:0]][nx[X_BITS-1:0]] == MINE)
              nbr_cnt = nbr_cnt + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    prng_d   = prng_q;
    px_d     = px_q;
    py_d     = py_q;
    nmines_d = nmines_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    we       = 1'b0;
    wx       = px_q;
    wy       = py_q;
    wd       = '0;
`ifdef BOARD_SAFE_START_EN
    safe_x_d = safe_x_q;
    safe_y_d = safe_y_q;
`endif
    case (state_q)
      S_IDLE, S_READY: begin
        if (bus.start) begin
          state_d  = S_CLEAR;
          prng_d   = (bus.seed_in == '0) ? SEED_DEF : bus.seed_in;
          px_d     = '0;
          py_d     = '0;
          nmines_d = '0;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
`ifdef BOARD_SAFE_START_EN
          safe_x_d = bus.safe_x;
          safe_y_d = bus.safe_y;
`endif
        end
      end
      S_CLEAR: begin
        we = 1'b1;
        if (px_q == X_LAST) begin
          px_d = '0;
          if (py_q == Y_LAST) begin
            py_d    = '0;
            state_d = S_PLACE;
          end else begin
            py_d = py_q + Y_ONE;
          end
        end else begin
          px_d = px_q + X_ONE;
        end
      end
      S_PLACE: begin
        prng_d = xorshift32(prng_q);
        if (nmines_q == MINES_TGT) begin
          state_d = S_COUNT;
        end else if (cand_free) begin
          we       = 1'b1;
          wx       = cand_x;
          wy       = cand_y;
          wd       = MINE;
          nmines_d = nmines_q + CNT_ONE;
        end
      end
      S_COUNT: begin
        if (mem_q[py_q][px_q] != MINE) begin
          we = 1'b1;
          wd = {1'b0, nbr_cnt};
        end
        if (px_q == X_LAST) begin
          px_d = '0;
          if (py_q == Y_LAST) begin
            py_d    = '0;
            state_d = S_READY;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            py_d = py_q + Y_ONE;
          end
        end else begin
          px_d = px_q + X_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prng_q   <= SEED_DEF;
      px_q     <= '0;
      py_q     <= '0;
      nmines_q <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prng_q   <= prng_d;
      px_q     <= px_d;
      py_q     <= py_d;
      nmines_q <= nmines_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Board storage has no reset; a partial board survives a reset.
  always_ff @(posedge clk) begin
    if (!reset && we)
      mem_q[wy][wx] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cell_val_q <= '0;
    else if (32'(bus.x_coord) < X_SIZE && 32'(bus.y_coord) < Y_SIZE)
      cell_val_q <= mem_q[bus.y_coord][bus.x_coord];
    else
      cell_val_q <= '0;
  end

  assign bus.cell_val  = cell_val_q;
  assign bus.num_mines = nmines_q;
  assign bus.busy      = busy_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_board_gen.sv
module tb_board_gen;

  localparam int XS = 16, YS = 16, XB = 4, YB = 4, NM = 40;
  localparam int SXS = 5, SYS = 3, SXB = 3, SYB = 2, SNM = 6;
`ifdef BOARD_SAFE_START_EN
  localparam bit SAFE_EN = 1'b1;
`else
  localparam bit SAFE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  board_gen_if #(.X_BITS(XB),  .Y_BITS(YB))  bus();
  board_gen_if #(.X_BITS(SXB), .Y_BITS(SYB)) sbus();

  board_gen #(.X_SIZE(XS), .Y_SIZE(YS), .X_BITS(XB), .Y_BITS(YB), .NUM_MINES(NM))
    u_dut (.clk(clk), .reset(reset), .bus(bus.slave));

  board_gen #(.X_SIZE(SXS), .Y_SIZE(SYS), .X_BITS(SXB), .Y_BITS(SYB), .NUM_MINES(SNM))
    u_small (.clk(clk), .reset(reset), .bus(sbus.slave));

  int total = 0;
  int bad   = 0;
  int exp_cell [256];
  int cap      [256];
  int saved    [256];
  int done_cnt  = 0;
  int sdone_cnt = 0;

  always @(negedge clk) begin
    if (bus.done)  done_cnt++;
    if (sbus.done) sdone_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xs32(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Reference board: draw candidates until nm mines are placed, then count
  // mines around every non-mine cell from the finished mine map.
  task automatic model(input logic [31:0] seed, input int xs, input int ys,
                       input int xb, input int yb, input int nm,
                       input int sx, input int sy, output int attempts);
    bit          mine [256];
    logic [31:0] r;
    int          placed, cx, cy, n;
    bit          ok, in_safe;
    foreach (mine[k]) mine[k] = 1'b0;
    r        = (seed == 0) ? 32'h1234_5678 : seed;
    placed   = 0;
    attempts = 0;
    while (placed < nm && attempts < 200000) begin
      cx      = int'(r & ((32'd1 << xb) - 1));
      cy      = int'((r >> xb) & ((32'd1 << yb) - 1));
      in_safe = (cx - sx <= 1) && (sx - cx <= 1) && (cy - sy <= 1) && (sy - cy <= 1);
      ok      = 1'b0;
      if (cx < xs && cy < ys) begin
        ok = !mine[cy*xs + cx];
        if (SAFE_EN && in_safe) ok = 1'b0;
      end
      if (ok) begin
        mine[cy*xs + cx] = 1'b1;
        placed++;
      end
      r = xs32(r);
      attempts++;
    end
    for (int y = 0; y < ys; y++) begin
      for (int x = 0; x < xs; x++) begin
        if (mine[y*xs + x]) begin
          exp_cell[y*xs + x] = 31;
        end else begin
          n = 0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
              if (x+dx >= 0 && x+dx < xs && y+dy >= 0 && y+dy < ys && mine[(y+dy)*xs + x+dx])
                n++;
          exp_cell[y*xs + x] = n;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_big(input logic [31:0] seed, input int sx, input int sy);
    bus.seed_in = seed;
    bus.safe_x  = sx[XB-1:0];
    bus.safe_y  = sy[YB-1:0];
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    check("busy_on_accept", bus.busy, 1);
    check("ready_on_accept", bus.ready, 0);
    check("num_mines_on_accept", bus.num_mines, 0);
  endtask

  task automatic wait_done_big(input string tag);
    int cyc;
    cyc = 1;
    while (!bus.done && cyc < 5000) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_min_latency"}, 32'(cyc >= 2*XS*YS + NM), 1);
    check({tag, "_ready"}, bus.ready, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_num_mines"}, bus.num_mines, NM);
    tick();
    check({tag, "_done_pulse"}, bus.done, 0);
  endtask

  task automatic read_big(input string tag);
    int mines;
    mines = 0;
    for (int y = 0; y < YS; y++) begin
      for (int x = 0; x < XS; x++) begin
        bus.x_coord = x[XB-1:0];
        bus.y_coord = y[YB-1:0];
        tick();
        cap[y*XS + x] = int'(bus.cell_val);
        if (cap[y*XS + x] == 31) mines++;
        check($sformatf("%s_cell_%0d_%0d", tag, x, y), bus.cell_val, exp_cell[y*XS + x]);
      end
    end
    check({tag, "_mine_total"}, mines, NM);
  endtask

  task automatic board_big(input string tag, input logic [31:0] seed, input int sx, input int sy);
    int att;
    model(seed, XS, YS, XB, YB, NM, sx, sy, att);
    start_big(seed, sx, sy);
    wait_done_big(tag);
    read_big(tag);
  endtask

  initial begin
    int att, d0, diff, cyc;
    logic [31:0] rs;
    reset        = 1'b1;
    bus.start    = 1'b0; bus.seed_in = '0; bus.safe_x = '0; bus.safe_y = '0;
    bus.x_coord  = '0;   bus.y_coord = '0;
    sbus.start   = 1'b0; sbus.seed_in = '0; sbus.safe_x = '0; sbus.safe_y = '0;
    sbus.x_coord = '0;   sbus.y_coord = '0;
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();

    // T1: reset state
    check("t1_busy", bus.busy, 0);
    check("t1_ready", bus.ready, 0);
    check("t1_done", bus.done, 0);
    check("t1_num_mines", bus.num_mines, 0);
    check("t1_cell_val", bus.cell_val, 0);
    check("t1_small_busy", sbus.busy, 0);
    check("t1_small_ready", sbus.ready, 0);

    // T2: default seed, full board against reference
    d0 = done_cnt;
    board_big("t2", 32'h1234_5678, 8, 8);
    check("t2_single_done", done_cnt - d0, 1);
    check("t2_corner_le3", 32'(cap[0] <= 3), 1);
    foreach (cap[k]) saved[k] = cap[k];

    // T4: seed 0 must reproduce the default-seed board
    board_big("t4_seed0", 32'h0, 8, 8);
    for (int k = 0; k < XS*YS; k++)
      check($sformatf("t4_seed0_eq_%0d", k), cap[k], saved[k]);

    // T4: same seed twice gives identical boards
    board_big("t4_dead_a", 32'hDEAD_BEEF, 8, 8);
    foreach (cap[k]) saved[k] = cap[k];
    board_big("t4_dead_b", 32'hDEAD_BEEF, 8, 8);
    for (int k = 0; k < XS*YS; k++)
      check($sformatf("t4_repeat_eq_%0d", k), cap[k], saved[k]);

    // T3: first-click safe zone at corners (no wrap to the far corner)
    board_big("t3_safe00", 32'hCAFE_F00D, 0, 0);
    if (SAFE_EN) begin
      check("t3_00_zero", cap[0], 0);
      check("t3_10_nomine", 32'(cap[1] != 31), 1);
      check("t3_01_nomine", 32'(cap[XS] != 31), 1);
      check("t3_11_nomine", 32'(cap[XS+1] != 31), 1);
    end
    board_big("t3_safeff", 32'h0BAD_F00D, 15, 15);
    if (SAFE_EN) begin
      check("t3_ff_zero", cap[XS*YS-1], 0);
      check("t3_ef_nomine", 32'(cap[XS*YS-2] != 31), 1);
      check("t3_fe_nomine", 32'(cap[XS*YS-1-XS] != 31), 1);
    end

    // Randomized seeds and safe cells
    for (int n = 0; n < 3; n++) begin
      rs = $urandom;
      board_big($sformatf("rnd%0d", n), rs, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
    end

    // T5: start during COUNT is ignored
    model(32'h0F0F_1234, XS, YS, XB, YB, NM, 3, 4, att);
    d0 = done_cnt;
    start_big(32'h0F0F_1234, 3, 4);
    repeat (XS*YS + att + 1 + 100) tick();
    check("t5_busy_in_count", bus.busy, 1);
    bus.seed_in = 32'h5555_AAAA;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 5000) begin
      tick();
      cyc++;
    end
    check("t5_done", bus.done, 1);
    repeat (20) tick();
    diff = done_cnt - d0;
    check("t5_single_done", diff, 1);
    read_big("t5");

    // T5: reset during PLACE
    start_big(32'h7777_0001, 8, 8);
    repeat (XS*YS + 10) tick();
    check("t5_busy_in_place", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_ready", bus.ready, 0);
    check("t5_rst_num_mines", bus.num_mines, 0);
    repeat (3) tick();
    check("t5_rst_idle_ready", bus.ready, 0);

    // Start and reset together: reset wins
    bus.seed_in = 32'h1111_2222;
    bus.start   = 1'b1;
    reset       = 1'b1;
    tick();
    bus.start   = 1'b0;
    reset       = 1'b0;
    check("t5_rst_start_busy", bus.busy, 0);
    board_big("t5_after_rst", 32'h7777_0001, 8, 8);

    // T6: small board, readback latency and out-of-range coordinates
    model(32'h2468_ACE1, SXS, SYS, SXB, SYB, SNM, 0, 0, att);
    d0 = sdone_cnt;
    sbus.seed_in = 32'h2468_ACE1;
    sbus.safe_x  = '0;
    sbus.safe_y  = '0;
    sbus.start   = 1'b1;
    tick();
    sbus.start   = 1'b0;
    check("t6_busy_on_accept", sbus.busy, 1);
    cyc = 1;
    while (!sbus.done && cyc < 5000) begin
      tick();
      cyc++;
    end
    check("t6_done", sbus.done, 1);
    check("t6_num_mines", sbus.num_mines, SNM);
    tick();
    check("t6_ready", sbus.ready, 1);
    check("t6_single_done", sdone_cnt - d0, 1);
    for (int y = 0; y < SYS; y++) begin
      for (int x = 0; x < SXS; x++) begin
        sbus.x_coord = x[SXB-1:0];
        sbus.y_coord = y[SYB-1:0];
        tick();
        check($sformatf("t6_cell_%0d_%0d", x, y), sbus.cell_val, exp_cell[y*SXS + x]);
      end
    end
    sbus.x_coord = 3'd4;
    sbus.y_coord = 2'd2;
    tick();
    check("t6_lat_4_2", sbus.cell_val, exp_cell[2*SXS + 4]);
    sbus.x_coord = 3'd7;
    sbus.y_coord = 2'd0;
    tick();
    check("t6_oor_x", sbus.cell_val, 0);
    sbus.x_coord = 3'd4;
    sbus.y_coord = 2'd2;
    tick();
    check("t6_lat_back", sbus.cell_val, exp_cell[2*SXS + 4]);
    sbus.x_coord = 3'd1;
    sbus.y_coord = 2'd3;
    tick();
    check("t6_oor_y", sbus.cell_val, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
